// File: rtl/i2c_pkg.sv
// ============================================================================
// Module      : i2c_pkg
// Description : Shared state encodings and constants for the I2C master TX.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package i2c_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_BIT   = 3'd2,
        ST_ACK   = 3'd3,
        ST_LOAD  = 3'd4,
        ST_STOP  = 3'd5
    } state_t;

    localparam logic [1:0] Q0 = 2'd0;
    localparam logic [1:0] Q1 = 2'd1;
    localparam logic [1:0] Q2 = 2'd2;
    localparam logic [1:0] Q3 = 2'd3;

    localparam logic RW_WRITE = 1'b0;

endpackage

`default_nettype wire

// File: rtl/i2c_qtr_timer.sv
// ============================================================================
// Module      : i2c_qtr_timer
// Description : SCL quarter-period timer with clear and stretch hold.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module i2c_qtr_timer #(
    parameter int QTR = 125
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       hold,
    output logic       qtr_tick,
    output logic [1:0] qtr
);

    localparam int CW = (QTR > 1) ? $clog2(QTR) : 1;
    localparam logic [CW-1:0] LAST = CW'(QTR - 1);

    logic [CW-1:0] cnt;

    assign qtr_tick = !clear && !hold && (cnt == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            qtr <= 2'd0;
        end else if (clear) begin
            cnt <= '0;
            qtr <= 2'd0;
        end else if (qtr_tick) begin
            cnt <= '0;
            qtr <= qtr + 2'd1;
        end else if (!hold) begin
            cnt <= cnt + {{(CW-1){1'b0}}, 1'b1};
        end
    end

endmodule

`default_nettype wire

// File: rtl/i2c_master_tx.sv
// ============================================================================
// Module      : i2c_master_tx
// Description : Byte-level I2C master write engine fed from a show-ahead FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module i2c_master_tx
    import i2c_pkg::*;
#(
    parameter int QTR = 125
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [6:0] dev_addr,
    input  logic [7:0] len,
    input  logic [7:0] fifo_dout,
    input  logic       fifo_empty,
    output logic       fifo_rd,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       scl_oe,
    output logic       sda_oe,
    output logic       busy,
    output logic       done,
    output logic       nack,
    output logic       underrun
);

    state_t     state, next_state;
    logic [7:0] shift;
    logic [7:0] remaining;
    logic [2:0] bit_cnt;
    logic       ack_bit;
    logic       tmr_clear, tmr_hold, qtr_tick, last;
    logic [1:0] qtr;

    i2c_qtr_timer #(.QTR(QTR)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .clear    (tmr_clear),
        .hold     (tmr_hold),
        .qtr_tick (qtr_tick),
        .qtr      (qtr)
    );

    assign last = qtr_tick && (qtr == Q3);
    assign busy = (state != ST_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= next_state;
    end

    // Line enables decode straight from registers so reset releases the pads at once.
    always_comb begin
        next_state = state;
        scl_oe     = 1'b0;
        sda_oe     = 1'b0;
        fifo_rd    = 1'b0;
        tmr_clear  = 1'b0;
        tmr_hold   = 1'b0;
        case (state)
            ST_IDLE: begin
                tmr_clear = 1'b1;
                if (start) next_state = ST_START;
            end
            ST_START: begin
                sda_oe = (qtr >= Q2);
                if (last) next_state = ST_BIT;
            end
            ST_BIT: begin
                scl_oe   = (qtr <= Q1);
                sda_oe   = ~shift[7];
                tmr_hold = (qtr == Q2) && !scl_i;
                if (last && bit_cnt == 3'd7) next_state = ST_ACK;
            end
            ST_ACK: begin
                scl_oe   = (qtr <= Q1);
                tmr_hold = (qtr == Q2) && !scl_i;
                if (last) begin
                    if (!ack_bit && remaining != 8'd0) next_state = ST_LOAD;
                    else                               next_state = ST_STOP;
                end
            end
            ST_LOAD: begin
                tmr_clear = 1'b1;
                scl_oe    = 1'b1;
                if (fifo_empty) begin
                    next_state = ST_STOP;
                end else begin
                    fifo_rd    = 1'b1;
                    next_state = ST_BIT;
                end
            end
            ST_STOP: begin
                scl_oe = (qtr == Q0);
                sda_oe = (qtr <= Q1);
                if (last) next_state = ST_IDLE;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift     <= '0;
            remaining <= '0;
            bit_cnt   <= '0;
            ack_bit   <= 1'b0;
            nack      <= 1'b0;
            underrun  <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= (state == ST_STOP) && last;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        shift     <= {dev_addr, RW_WRITE};
                        remaining <= len;
                        bit_cnt   <= 3'd0;
                        nack      <= 1'b0;
                        underrun  <= 1'b0;
                    end
                end
                ST_BIT: begin
                    if (last) begin
                        shift   <= {shift[6:0], 1'b0};
                        bit_cnt <= bit_cnt + 3'd1;
                    end
                end
                ST_ACK: begin
                    if (qtr_tick && qtr == Q2) ack_bit <= sda_i;
                    if (last && ack_bit)       nack    <= 1'b1;
                end
                ST_LOAD: begin
                    if (fifo_empty) begin
                        underrun <= 1'b1;
                    end else begin
                        shift     <= fifo_dout;
                        remaining <= remaining - 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_i2c_master_tx.sv
// ============================================================================
// Module      : tb_i2c_master_tx
// Description : Self-checking bench: bus-level monitor, slave and FIFO model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_i2c_master_tx;

    localparam int Q = 2;

    typedef struct {
        logic [6:0]      addr;
        int              len;
        int              nfifo;
        int              ack_n;
        logic [3:0][7:0] data;
        bit              extra_start;
        int              exp_cyc;
        bit              exp_nack;
        bit              exp_und;
        int              exp_rd;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic [6:0] dev_addr = '0;
    logic [7:0] len = '0;
    logic [7:0] fifo_dout;
    logic       fifo_empty, fifo_rd;
    logic       scl_i, sda_i, scl_oe, sda_oe;
    logic       busy, done, nack, underrun;

    logic       stretch = 1'b0;
    logic       slave_drive = 1'b0;
    int         ack_n = 9;
    int         checks = 0;
    int         errors = 0;

    assign scl_i = ~scl_oe & ~stretch;
    assign sda_i = ~sda_oe & ~slave_drive;

    i2c_master_tx #(.QTR(Q)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .dev_addr   (dev_addr),
        .len        (len),
        .fifo_dout  (fifo_dout),
        .fifo_empty (fifo_empty),
        .fifo_rd    (fifo_rd),
        .scl_i      (scl_i),
        .sda_i      (sda_i),
        .scl_oe     (scl_oe),
        .sda_oe     (sda_oe),
        .busy       (busy),
        .done       (done),
        .nack       (nack),
        .underrun   (underrun)
    );

    always #5 clk = ~clk;

    // Show-ahead FIFO model
    logic [7:0] fmem [0:15];
    logic [3:0] rp = 4'd0;
    logic [3:0] wp = 4'd0;
    int         rd_total = 0;
    int         done_total = 0;
    assign fifo_empty = (rp == wp);
    assign fifo_dout  = fmem[rp];

    always @(posedge clk) begin
        if (fifo_rd) begin
            rd_total <= rd_total + 1;
            if (!fifo_empty) rp <= rp + 4'd1;
        end
        if (done) done_total <= done_total + 1;
    end

    // Bus monitor + ACKing slave: decodes bytes on SCL rising edges
    logic       p_scl = 1'b1, p_sda = 1'b1;
    int         bitcnt = 0, nbytes = 0;
    logic [7:0] cur = '0;
    logic [7:0] obs_mem [0:15];

    always @(negedge clk) begin
        if (p_scl && scl_i && (sda_i != p_sda)) begin
            if (!sda_i) begin
                bitcnt <= 0;
                nbytes <= 0;
            end
        end else if (!p_scl && scl_i) begin
            if (bitcnt == 8) begin
                obs_mem[nbytes[3:0]] <= cur;
                nbytes <= nbytes + 1;
                bitcnt <= 0;
            end else begin
                cur    <= {cur[6:0], sda_i};
                bitcnt <= bitcnt + 1;
            end
        end else if (p_scl && !scl_i) begin
            slave_drive <= (bitcnt == 8) && (nbytes < ack_n);
        end
        p_scl <= scl_i;
        p_sda <= sda_i;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Clock-stretch agent: holds SCL low 50 cycles from the q2 of address bit 3
    logic arm = 1'b0;
    initial begin
        int   falls;
        logic prev_oe;
        logic sda_ref;
        int   bad;
        falls   = 0;
        prev_oe = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (arm && prev_oe && !scl_oe) falls++;
            prev_oe = scl_oe;
            if (arm && falls == 4) begin
                stretch = 1'b1;
                sda_ref = sda_oe;
                bad     = 0;
                repeat (50) begin
                    @(posedge clk);
                    #1;
                    if (sda_oe != sda_ref) bad++;
                end
                stretch = 1'b0;
                chk("stretch_sda_stable", bad, 0);
                arm     = 1'b0;
                falls   = 0;
                prev_oe = scl_oe;
            end
        end
    end

    function automatic vec_t mk(logic [6:0] a, int l, int nf, int an, logic [31:0] d,
                                bit ex, int cyc, bit nk, bit un, int rd);
        vec_t v;
        v.addr = a; v.len = l; v.nfifo = nf; v.ack_n = an; v.data = d;
        v.extra_start = ex; v.exp_cyc = cyc; v.exp_nack = nk; v.exp_und = un; v.exp_rd = rd;
        return v;
    endfunction

    // Reference: walk the byte sequence the bus should carry and count its cost
    function automatic vec_t model(vec_t v);
        vec_t r = v;
        int   sent = 1, loads = 0, rd = 0;
        bit   nk = 0, un = 0;
        for (int k = 0; k < 16; k++) begin
            if (sent - 1 >= v.ack_n) begin nk = 1; break; end
            if (rd == v.len) break;
            loads++;
            if (rd >= v.nfifo) begin un = 1; break; end
            rd++;
            sent++;
        end
        r.exp_cyc  = 4 * Q * (2 + 9 * sent) + loads;
        r.exp_nack = nk;
        r.exp_und  = un;
        r.exp_rd   = rd;
        return r;
    endfunction

    task automatic load_fifo(input vec_t v);
        wp = rp;
        for (int i = 0; i < v.nfifo; i++) begin
            fmem[wp] = v.data[i];
            wp = wp + 4'd1;
        end
        ack_n    = v.ack_n;
        dev_addr = v.addr;
        len      = v.len[7:0];
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int cyc, rd0, dn0;
        bit got;
        load_fifo(v);
        rd0 = rd_total;
        dn0 = done_total;
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        chk({tag, "_busy_rise"}, busy, 1);
        cyc = 0;
        got = 0;
        while (!got && cyc < 4000) begin
            @(posedge clk);
            #1;
            cyc++;
            start = (v.extra_start && cyc == 20);
            if (done) got = 1;
        end
        start = 1'b0;
        chk({tag, "_done_cycle"}, cyc, v.exp_cyc);
        chk({tag, "_busy_at_done"}, busy, 0);
        chk({tag, "_nack"}, nack, v.exp_nack);
        chk({tag, "_underrun"}, underrun, v.exp_und);
        chk({tag, "_fifo_rd"}, rd_total - rd0, v.exp_rd);
        chk({tag, "_bytes"}, nbytes, v.exp_rd + 1);
        chk({tag, "_byte_addr"}, obs_mem[0], {v.addr, 1'b0});
        for (int i = 0; i < v.exp_rd && i < nbytes - 1; i++)
            chk({tag, "_byte_data"}, obs_mem[i+1], v.data[i]);
        @(posedge clk);
        #1;
        chk({tag, "_done_pulse"}, done, 0);
        chk({tag, "_done_count"}, done_total - dn0, 1);
        repeat (3) @(posedge clk);
        #1 chk({tag, "_idle_after"}, busy, 0);
    endtask

    vec_t vecs [12];

    initial begin
        vec_t v;
        int   dn0;

        vecs[0] = mk(7'h50, 2, 2, 9, 32'h0000_3CA5, 0, 234, 0, 0, 2);
        vecs[1] = mk(7'h50, 0, 0, 0, 32'h0,         0,  88, 1, 0, 0);
        vecs[2] = mk(7'h2A, 3, 1, 9, 32'h0000_0011, 0, 162, 0, 1, 1);
        vecs[3] = mk(7'h7F, 0, 0, 9, 32'h0,         0,  88, 0, 0, 0);
        vecs[4] = mk(7'h13, 3, 3, 2, 32'h0003_0201, 0, 234, 1, 0, 2);
        vecs[5] = mk(7'h21, 1, 1, 9, 32'h0000_00C3, 1, 161, 0, 0, 1);
        for (int i = 6; i < 12; i++) begin
            v = mk(7'($urandom), int'($urandom_range(0, 4)), int'($urandom_range(0, 4)),
                   9, $urandom, 0, 0, 0, 0, 0);
            if ($urandom_range(0, 2) == 0) v.ack_n = int'($urandom_range(0, 4));
            vecs[i] = model(v);
        end

        #1 rst = 1'b1;
        #1;
        chk("rst_fifo_rd", fifo_rd, 0);
        chk("rst_scl_oe", scl_oe, 0);
        chk("rst_sda_oe", sda_oe, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_nack", nack, 0);
        chk("rst_underrun", underrun, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 12; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Clock stretching during address bit 3
        arm = 1'b1;
        run_vec(mk(7'h55, 1, 1, 9, 32'h0000_0096, 0, 161 + 50, 0, 0, 1), "stretch");

        // Reset in the middle of the first data bit
        v = mk(7'h3A, 1, 1, 9, 32'h0000_005A, 0, 161, 0, 0, 1);
        load_fifo(v);
        dn0 = done_total;
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (82) @(posedge clk);
        #1;
        chk("midrst_scl_before", scl_oe, 1);
        chk("midrst_busy_before", busy, 1);
        #1 rst = 1'b1;
        #1;
        chk("midrst_scl_oe", scl_oe, 0);
        chk("midrst_sda_oe", sda_oe, 0);
        chk("midrst_busy", busy, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("midrst_no_done", done_total - dn0, 0);
        run_vec(v, "after_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/i2c_master_tx.md
# i2c_master_tx

Byte-level I2C master write engine that sits directly downstream of the TX sync FIFO. On a start pulse it issues START, sends the 7-bit device address with the write bit, then pops and serialises `len` data bytes from the FIFO. It checks the slave ACK after every byte and finishes with STOP. Outputs are open-drain enables for the pad cells; the block tolerates slave clock stretching.

## Interface
- `QTR`, default 125: clk cycles per SCL quarter-period; minimum legal value 2.
- `clk`  in  1: system clock.
- `rst`  in  1: asynchronous, active-high reset.
- `start`  in  1: one-cycle request; sampled only in IDLE.
- `dev_addr`  in  7: slave address; latched on accepted start.
- `len`  in  8: number of data bytes (0 = address-only probe); latched on accepted start.
- `fifo_dout`  in  8: FIFO head word; valid whenever `fifo_empty`=0.
- `fifo_empty`  in  1: FIFO empty flag.
- `fifo_rd`  out  1: pop strobe; one cycle per byte.
- `scl_i`, `sda_i`  in  1: synchronised pad inputs.
- `scl_oe`, `sda_oe`  out  1: 1 = drive line low, 0 = release.
- `busy`  out  1: transaction in progress.
- `done`  out  1: one-cycle pulse at end of transaction.
- `nack`  out  1: sticky; slave NACKed; cleared on the next accepted start.
- `underrun`  out  1: sticky; FIFO was empty when a byte was due; cleared on the next accepted start.

## Operation
- Reset values: `fifo_rd`=0, `scl_oe`=0, `sda_oe`=0, `busy`=0, `done`=0, `nack`=0, `underrun`=0; state IDLE.
- States:
  - IDLE: lines released. `start` moves to START; `busy` goes high the next cycle.
  - START, quarters q0–q3: q0–q1 SDA and SCL released; q2–q3 SDA low, SCL released. Then go to BIT with shift = {dev_addr,1'b0}.
  - BIT, 8 bits, MSB first, quarters per bit:
    - q0–q1: SCL low, SDA = shift MSB (`sda_oe` = ~bit).
    - q2–q3: SCL released.
  - ACK: same quarter pattern with SDA released. `sda_i` is sampled at the q2→q3 boundary; 1 means NACK.
  - ACK outcome:
    - On NACK: set `nack`, go to STOP.
    - On ACK with bytes remaining: go to LOAD.
    - Otherwise go to STOP.
  - LOAD: single cycle.
    - If `fifo_empty`=1: set `underrun`, go to STOP.
    - Else: assert `fifo_rd`, capture `fifo_dout` into shift in the same cycle, decrement remaining count, go to BIT.
  - STOP, quarters:
    - q0: SCL low, SDA low.
    - q1: SCL released, SDA low.
    - q2–q3: both released.
    - Then `done`=1 for one cycle, `busy`=0 in that same cycle, return to IDLE.
- Remaining-byte counter is 8-bit, loaded from `len`, and never wraps: LOAD is entered only when the counter is non-zero.
- Clock stretching: in q2 of BIT or ACK, the quarter timer holds while `scl_i`=0. Timing resumes from the first cycle `scl_i`=1.
- `start` while `busy`=1 is ignored; no queuing.
- No bytes are popped after a NACK or an underrun.
- Reset mid-transaction: lines release asynchronously, state returns to IDLE, and no `done` pulse is generated.

## Timing
- Quarter = `QTR` cycles, with no stretching. Bit = 4·QTR.
- Transaction length, start accepted to `done` cycle: 4·QTR·(2 + 9·(len+1)) + len cycles. The `len` term is one LOAD cycle per byte.
- `fifo_rd` is asserted at most once per 36·QTR cycles.
- The FIFO head must already be valid in the LOAD cycle, which matches the FIFO show-ahead output.
- SDA changes only while SCL is low, except START q2 and STOP q2.

## Structure
- Shared `i2c_pkg` holds:
  - state encodings: IDLE, START, BIT, ACK, LOAD, STOP;
  - quarter indices;
  - the R/W bit constant.
- Sub-module `i2c_qtr_timer`: counts 0..QTR-1, emits a `qtr_tick` and a 2-bit quarter index, and takes a `hold` input for stretching. The main FSM, shift register and byte counter stay in `i2c_master_tx`.

## Test plan
- QTR=2, dev_addr=7'h50, len=2, FIFO holds 8'hA5, 8'h3C, slave ACKs all bytes:
  - SDA bits 1010_0000, A5, 3C observed on SCL rising edges;
  - two `fifo_rd` pulses;
  - `done` at cycle 4·2·29+2 = 234;
  - `nack`=0, `underrun`=0.
- len=0 probe, slave NACKs the address:
  - `nack`=1, no `fifo_rd`;
  - STOP follows immediately;
  - `done` after 4·2·11 = 88 cycles.
- len=3, FIFO holds 1 byte:
  - one `fifo_rd`, then `underrun`=1 at the second LOAD;
  - STOP issued; `done` pulses.
- Slave holds `scl_i` low for 50 cycles during bit 3 of the address:
  - all timing shifts by exactly 50 cycles;
  - no SDA change while SCL is held low.
- `rst` asserted mid-data-byte:
  - `scl_oe`/`sda_oe`/`busy` drop without waiting for a clock edge;
  - no `done`;
  - a following start of len=1 completes normally.
- `start` pulsed while busy: ignored, with the same `fifo_rd` count as a single transaction.
